// File: rtl/mul_pkg.sv
// Shared types and defaults for the Booth multiplier and the controller that arbitrates access to it.
// No logic here, so no latency or backpressure.
package mul_pkg;

    localparam int WIDTH       = 32;
    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        CAPTURE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mul_rr_picker.sv
// Round-robin picker: first asserted request at or above i_rr_ptr, with wrap-around.
// Purely combinational (zero latency); does not apply backpressure itself.
module mul_rr_picker
    import mul_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDXW-1:0]    o_grant_idx,
    output logic               o_any
);

    int w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDXW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one mul_datapath among NUM_REQ requesters; accept-to-start 1 cycle, done-to-response 2 cycles.
// One job in flight: no request accepted until the response handshakes, response held until rsp_ready_i.
module mul_arbiter #(
    parameter int WIDTH   = mul_pkg::WIDTH,
    parameter int NUM_REQ = mul_pkg::ARB_NUM_REQ,
    parameter int TIMEOUT = mul_pkg::ARB_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [2*WIDTH-1:0]         rsp_product_o,
    output logic                       rsp_err_o,
    output logic                       mul_start_o,
    output logic [WIDTH-1:0]           mul_multiplicand_o,
    output logic [WIDTH-1:0]           mul_multiplier_o,
    input  logic                       mul_done_i,
    input  logic [2*WIDTH-1:0]         mul_product_i
);
    import mul_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [IDW-1:0]     r_rr_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDW-1:0]     r_id;
    logic [2*WIDTH-1:0] r_product;
    logic               r_err;
    logic               r_rsp_valid;
    logic               r_start;
    logic [CW-1:0]      r_wd_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_any;
    logic               w_accept;
    logic               w_timeout;

    mul_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDW)
    ) u_picker (
        .i_req       (req_valid_i),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_timeout = (r_wd_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !rst) begin
                    w_accept = 1'b1;
                    w_next   = START;
                end
            end
            START:   w_next = BUSY;
            // done has priority over a coincident watchdog expiry
            BUSY: begin
                if (mul_done_i)     w_next = CAPTURE;
                else if (w_timeout) w_next = RESP;
            end
            CAPTURE: w_next = RESP;
            RESP: begin
                if (rsp_ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_product   <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_start     <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_start     <= (w_next == START);
            r_rsp_valid <= (w_next == RESP);
            if (w_accept) begin
                r_a      <= req_a_i[int'(w_grant_idx)*WIDTH +: WIDTH];
                r_b      <= req_b_i[int'(w_grant_idx)*WIDTH +: WIDTH];
                r_id     <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == START) begin
                r_wd_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (r_state == BUSY && !mul_done_i && w_timeout) begin
                r_product <= '0;
                r_err     <= 1'b1;
            end
            if (r_state == CAPTURE) begin
                r_product <= mul_product_i;
                r_err     <= 1'b0;
            end
        end
    end

    assign req_ready_o        = (r_state == IDLE && !rst) ? w_grant : '0;
    assign rsp_valid_o        = r_rsp_valid;
    assign rsp_id_o           = r_id;
    assign rsp_product_o      = r_product;
    assign rsp_err_o          = r_err;
    assign mul_start_o        = r_start;
    assign mul_multiplicand_o = r_a;
    assign mul_multiplier_o   = r_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier stub of programmable done latency.
module tb_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid_i;
    logic [N-1:0]     req_ready_o;
    logic [N*W-1:0]   req_a_i;
    logic [N*W-1:0]   req_b_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [1:0]       rsp_id_o;
    logic [2*W-1:0]   rsp_product_o;
    logic             rsp_err_o;
    logic             mul_start_o;
    logic [W-1:0]     mul_multiplicand_o;
    logic [W-1:0]     mul_multiplier_o;
    logic             mul_done_i;
    logic [2*W-1:0]   mul_product_i = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // datapath stub: done pulses stub_lat edges after the start pulse is seen
    logic stub_done  = 1'b0;
    logic force_done = 1'b0;
    bit   stub_en    = 1'b1;
    bit   stub_busy  = 1'b0;
    int   stub_lat   = 4;
    int   stub_cnt   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (mul_start_o) begin
            stub_busy     <= 1'b1;
            stub_cnt      <= stub_lat;
            mul_product_i <= {32'b0, mul_multiplicand_o} * {32'b0, mul_multiplier_o};
        end else if (stub_busy) begin
            if (stub_cnt <= 1) begin
                stub_busy <= 1'b0;
                stub_done <= stub_en;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    assign mul_done_i = stub_done | force_done;

    mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_a_i            (req_a_i),
        .req_b_i            (req_b_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_id_o           (rsp_id_o),
        .rsp_product_o      (rsp_product_o),
        .rsp_err_o          (rsp_err_o),
        .mul_start_o        (mul_start_o),
        .mul_multiplicand_o (mul_multiplicand_o),
        .mul_multiplier_o   (mul_multiplier_o),
        .mul_done_i         (mul_done_i),
        .mul_product_i      (mul_product_i)
    );

    // Called at a negedge; t = cycle of the handshake, returns at negedge of t+1 with valid dropped.
    task automatic accept(input int id, input logic [W-1:0] a, input logic [W-1:0] b, output int t);
        req_a_i[id*W +: W] = a;
        req_b_i[id*W +: W] = b;
        req_valid_i[id]    = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (req_ready_o[id]) begin
                t = cyc;
                @(negedge clk);
                req_valid_i[id] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid_i[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid_o) begin
                t = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_rsp();
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        req_valid_i = '1;
        rsp_ready_i = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0000) begin
            fails++; $display("FAIL reset_ready: got %b want 0000", req_ready_o);
        end
        tests++;
        if ({rsp_valid_o, rsp_err_o, mul_start_o} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000", {rsp_valid_o, rsp_err_o, mul_start_o});
        end
        tests++;
        if ({rsp_id_o, rsp_product_o, mul_multiplicand_o, mul_multiplier_o} !== '0) begin
            fails++; $display("FAIL reset_data: got id=%0d p=%h a=%h b=%h want all 0",
                              rsp_id_o, rsp_product_o, mul_multiplicand_o, mul_multiplier_o);
        end
        rst         = 1'b0;
        req_valid_i = 4'b0110;
        #1;
        tests++;
        if (req_ready_o !== 4'b0010) begin
            fails++; $display("FAIL reset_rrptr: got %b want 0010", req_ready_o);
        end
        req_valid_i = '0;
    endtask

    task automatic test_single();
        int t, tr;
        stub_lat = 4;
        accept(2, 32'h7, 32'h3, t);
        tests++;
        if (t < 0) begin fails++; $display("FAIL single_accept: got no accept want accept"); end
        tests++;
        if (mul_start_o !== 1'b1) begin fails++; $display("FAIL single_start: got %b want 1", mul_start_o); end
        tests++;
        if (mul_multiplicand_o !== 32'h7 || mul_multiplier_o !== 32'h3) begin
            fails++; $display("FAIL single_ops: got %h/%h want 7/3", mul_multiplicand_o, mul_multiplier_o);
        end
        @(negedge clk);
        tests++;
        if (mul_start_o !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %b want 0", mul_start_o); end
        wait_rsp(tr);
        tests++;
        if (tr !== t + 8) begin fails++; $display("FAIL single_latency: got %0d want %0d", tr, t + 8); end
        tests++;
        if (rsp_id_o !== 2'd2 || rsp_product_o !== 64'h15 || rsp_err_o !== 1'b0) begin
            fails++; $display("FAIL single_rsp: got id=%0d p=%h err=%b want 2/15/0", rsp_id_o, rsp_product_o, rsp_err_o);
        end
        release_rsp();
    endtask

    task automatic test_fairness();
        int order[5];
        int acc[5];
        int rid[5];
        int rc[5];
        int ng = 0, nr = 0, t;
        logic [2*W-1:0] p0 = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stub_lat = 2;
        for (int k = 0; k < N; k++) begin
            req_a_i[k*W +: W] = W'(k + 1);
            req_b_i[k*W +: W] = 32'd10;
        end
        rsp_ready_i = 1'b1;
        req_valid_i = '1;
        for (int i = 0; i < 400 && ng < 5; i++) begin
            #1;
            if (rsp_valid_o && nr < 5) begin
                rid[nr] = int'(rsp_id_o);
                rc[nr]  = cyc;
                if (nr == 0) p0 = rsp_product_o;
                nr++;
            end
            if (req_ready_o != '0) begin
                for (int b = 0; b < N; b++) if (req_ready_o[b]) order[ng] = b;
                acc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        req_valid_i = '0;
        tests++;
        if (ng != 5) begin fails++; $display("FAIL fair_count: got %0d grants want 5", ng); end
        for (int k = 0; k < ng; k++) begin
            tests++;
            if (order[k] != k % N) begin fails++; $display("FAIL fair_order%0d: got %0d want %0d", k, order[k], k % N); end
        end
        for (int k = 0; k < nr && k < 4; k++) begin
            tests++;
            if (rid[k] != k) begin fails++; $display("FAIL fair_rspid%0d: got %0d want %0d", k, rid[k], k); end
        end
        tests++;
        if (nr < 1 || ng < 2 || acc[1] != rc[0] + 1) begin
            fails++; $display("FAIL fair_gap: got accept %0d after rsp %0d want rsp+1", acc[1], rc[0]);
        end
        tests++;
        if (p0 !== 64'd10) begin fails++; $display("FAIL fair_product: got %h want a", p0); end
        wait_rsp(t);
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int t, tr;
        bit stable = 1'b1, noready = 1'b1, nostart = 1'b1;
        stub_lat = 3;
        accept(1, 32'h1234, 32'h10, t);
        req_valid_i = 4'b1001;
        wait_rsp(tr);
        tests++;
        if (rsp_id_o !== 2'd1 || rsp_product_o !== 64'h12340) begin
            fails++; $display("FAIL bp_rsp: got id=%0d p=%h want 1/12340", rsp_id_o, rsp_product_o);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || rsp_product_o !== 64'h12340) stable = 1'b0;
            if (req_ready_o !== '0) noready = 1'b0;
            if (mul_start_o !== 1'b0) nostart = 1'b0;
        end
        tests++;
        if (!stable) begin fails++; $display("FAIL bp_stable: got changing response want held"); end
        tests++;
        if (!noready) begin fails++; $display("FAIL bp_noready: got ready asserted want 0"); end
        tests++;
        if (!nostart) begin fails++; $display("FAIL bp_nostart: got start pulse want 0"); end
        req_valid_i = '0;
        release_rsp();
        tests++;
        if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL bp_release: got %b want 0", rsp_valid_o); end
    endtask

    task automatic test_watchdog();
        int t, tr;
        bit spur = 1'b0;
        stub_en = 1'b0;
        stub_lat = 4;
        accept(3, 32'h5, 32'h5, t);
        wait_rsp(tr);
        tests++;
        if (tr !== t + 2 + TO) begin fails++; $display("FAIL wd_latency: got %0d want %0d", tr, t + 2 + TO); end
        tests++;
        if (rsp_err_o !== 1'b1 || rsp_product_o !== '0 || rsp_id_o !== 2'd3) begin
            fails++; $display("FAIL wd_rsp: got err=%b p=%h id=%0d want 1/0/3", rsp_err_o, rsp_product_o, rsp_id_o);
        end
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_product_o !== '0) begin
            fails++; $display("FAIL wd_late_done: got v=%b err=%b p=%h want 1/1/0", rsp_valid_o, rsp_err_o, rsp_product_o);
        end
        release_rsp();
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid_o !== 1'b0 || mul_start_o !== 1'b0) spur = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (spur) begin fails++; $display("FAIL wd_idle_done: got activity want none"); end
        stub_en = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        int t, tr;
        stub_lat = 20;
        accept(1, 32'h9, 32'h9, t);
        stub_lat = 4;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({rsp_valid_o, rsp_err_o, mul_start_o} !== 3'b000) begin
            fails++; $display("FAIL rstb_ctrl: got %b want 000", {rsp_valid_o, rsp_err_o, mul_start_o});
        end
        tests++;
        if ({rsp_id_o, rsp_product_o, mul_multiplicand_o, mul_multiplier_o} !== '0) begin
            fails++; $display("FAIL rstb_data: got id=%0d p=%h a=%h b=%h want all 0",
                              rsp_id_o, rsp_product_o, mul_multiplicand_o, mul_multiplier_o);
        end
        req_valid_i = '1;
        #1;
        tests++;
        if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL rstb_rrptr: got %b want 0001", req_ready_o); end
        req_valid_i = '0;
        @(negedge clk);
        accept(0, 32'hFFFF_FFFF, 32'h2, t);
        wait_rsp(tr);
        tests++;
        if (rsp_id_o !== 2'd0 || rsp_product_o !== 64'h1_FFFF_FFFE || rsp_err_o !== 1'b0) begin
            fails++; $display("FAIL rstb_rsp: got id=%0d p=%h err=%b want 0/1fffffffe/0", rsp_id_o, rsp_product_o, rsp_err_o);
        end
        release_rsp();
    endtask

    task automatic test_done_timeout_race();
        int t, tr;
        stub_lat = TO - 1;
        accept(2, 32'd100, 32'd3, t);
        wait_rsp(tr);
        tests++;
        if (tr !== t + 3 + TO) begin fails++; $display("FAIL race_latency: got %0d want %0d", tr, t + 3 + TO); end
        tests++;
        if (rsp_err_o !== 1'b0 || rsp_product_o !== 64'd300) begin
            fails++; $display("FAIL race_rsp: got err=%b p=%h want 0/12c", rsp_err_o, rsp_product_o);
        end
        release_rsp();
        stub_lat = TO;
        accept(0, 32'd100, 32'd3, t);
        wait_rsp(tr);
        tests++;
        if (tr !== t + 2 + TO) begin fails++; $display("FAIL late_latency: got %0d want %0d", tr, t + 2 + TO); end
        @(negedge clk);
        tests++;
        if (rsp_err_o !== 1'b1 || rsp_product_o !== '0) begin
            fails++; $display("FAIL late_rsp: got err=%b p=%h want 1/0", rsp_err_o, rsp_product_o);
        end
        release_rsp();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_reset_mid_busy();
        test_done_timeout_race();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
